// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: bundle of the two requester handshakes, the two response
// handshakes, the external barrel-shifter hookup and the busy flag.
//   master : requester / shifter side (drives requests, rsp_ready, sh_result, sh_cf)
//   slave  : arbiter side (drives req_ready, responses, sh_* controls, busy)
interface shift_arbiter_if;
   logic        req_valid0, req_valid1;
   logic        req_ready0, req_ready1;
   logic [31:0] req_src0, req_src1;
   logic [31:0] req_dst0, req_dst1;
   logic [1:0]  req_op0, req_op1;
   logic        rsp_valid0, rsp_valid1;
   logic        rsp_ready0, rsp_ready1;
   logic [31:0] rsp_result0, rsp_result1;
   logic        rsp_cf0, rsp_cf1;
   logic [31:0] sh_src, sh_dst;
   logic        sh_left, sh_right, sh_math;
   logic [31:0] sh_result;
   logic        sh_cf;
   logic        busy;

   modport master (
      output req_valid0, req_valid1, req_src0, req_src1, req_dst0, req_dst1,
             req_op0, req_op1, rsp_ready0, rsp_ready1, sh_result, sh_cf,
      input  req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_result0,
             rsp_result1, rsp_cf0, rsp_cf1, sh_src, sh_dst, sh_left, sh_right,
             sh_math, busy
   );

   modport slave (
      input  req_valid0, req_valid1, req_src0, req_src1, req_dst0, req_dst1,
             req_op0, req_op1, rsp_ready0, rsp_ready1, sh_result, sh_cf,
      output req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_result0,
             rsp_result1, rsp_cf0, rsp_cf1, sh_src, sh_dst, sh_left, sh_right,
             sh_math, busy
   );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-port front end for the EX-stage barrel shifter.
// Accepts one request at a time (round-robin or fixed priority), drives the
// shifter for one EXEC cycle, registers result/carry and holds the response
// on the owner port until it is taken.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : shift_arbiter_if.slave (requests, responses, sh_* hookup, busy)
//   FIXED_PRIO : 0 = round-robin on simultaneous requests, 1 = port 0 wins
module shift_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input logic            clk,
   input logic            rst,
   shift_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state;
   logic        rr_ptr;
   logic        owner;
   logic [1:0]  op_q;
   logic [31:0] sh_src_q, sh_dst_q;
   logic        left_q, right_q, math_q;
   logic        rsp_valid0_q, rsp_valid1_q;
   logic [31:0] res0_q, res1_q;
   logic        cf0_q, cf1_q;

   logic        grant0, grant1;
   logic [1:0]  sel_op;
   logic [31:0] cap_result;
   logic        cap_cf;
   logic        rsp_taken;

   // Grant depends only on req_valid*, state and pointer.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE) begin
         if (bus.req_valid0 && bus.req_valid1) begin
            if (FIXED_PRIO || !rr_ptr) grant0 = 1'b1;
            else                       grant1 = 1'b1;
         end else begin
            grant0 = bus.req_valid0;
            grant1 = bus.req_valid1;
         end
      end
   end

   always_comb begin
      sel_op     = grant1 ? bus.req_op1 : bus.req_op0;
      // Pass-through bypasses the shifter entirely.
      cap_result = (op_q == 2'b11) ? sh_dst_q : bus.sh_result;
      cap_cf     = (op_q == 2'b11) ? 1'b0     : bus.sh_cf;
      rsp_taken  = owner ? bus.rsp_ready1 : bus.rsp_ready0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= 1'b0;
         owner        <= 1'b0;
         op_q         <= '0;
         sh_src_q     <= '0;
         sh_dst_q     <= '0;
         left_q       <= 1'b0;
         right_q      <= 1'b0;
         math_q       <= 1'b0;
         rsp_valid0_q <= 1'b0;
         rsp_valid1_q <= 1'b0;
         res0_q       <= '0;
         res1_q       <= '0;
         cf0_q        <= 1'b0;
         cf1_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  owner    <= grant1;
                  rr_ptr   <= ~grant1;
                  op_q     <= sel_op;
                  sh_src_q <= grant1 ? bus.req_src1 : bus.req_src0;
                  sh_dst_q <= grant1 ? bus.req_dst1 : bus.req_dst0;
                  // Controls are registered so they are high exactly during EXEC.
                  left_q   <= (sel_op == 2'b00);
                  right_q  <= (sel_op == 2'b01);
                  math_q   <= (sel_op == 2'b10);
                  state    <= EXEC;
               end
            end
            EXEC: begin
               left_q  <= 1'b0;
               right_q <= 1'b0;
               math_q  <= 1'b0;
               if (owner) begin
                  res1_q       <= cap_result;
                  cf1_q        <= cap_cf;
                  rsp_valid1_q <= 1'b1;
               end else begin
                  res0_q       <= cap_result;
                  cf0_q        <= cap_cf;
                  rsp_valid0_q <= 1'b1;
               end
               state <= RESP;
            end
            RESP: begin
               if (rsp_taken) begin
                  rsp_valid0_q <= 1'b0;
                  rsp_valid1_q <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready0  = grant0;
   assign bus.req_ready1  = grant1;
   assign bus.rsp_valid0  = rsp_valid0_q;
   assign bus.rsp_valid1  = rsp_valid1_q;
   assign bus.rsp_result0 = res0_q;
   assign bus.rsp_result1 = res1_q;
   assign bus.rsp_cf0     = cf0_q;
   assign bus.rsp_cf1     = cf1_q;
   assign bus.sh_src      = sh_src_q;
   assign bus.sh_dst      = sh_dst_q;
   assign bus.sh_left     = left_q;
   assign bus.sh_right    = right_q;
   assign bus.sh_math     = math_q;
   assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed self-checking bench for shift_arbiter.
// Two instances: round-robin (bus) and fixed-priority (fbus). The bench
// plays both requesters and the external barrel shifter.
module tb_shift_arbiter;

   logic clk;
   logic rst;
   logic cf_drive;
   int   n_total;
   int   n_bad;

   shift_arbiter_if bus ();
   shift_arbiter_if fbus ();

   shift_arbiter #(.FIXED_PRIO(1'b0)) u_rr (.clk(clk), .rst(rst), .bus(bus));
   shift_arbiter #(.FIXED_PRIO(1'b1)) u_fp (.clk(clk), .rst(rst), .bus(fbus));

   // External shifter; with no control active it returns junk so a
   // pass-through result has to come from the latched operand.
   function automatic logic [31:0] shifter_model(input logic l, input logic r,
                                                 input logic m, input logic [31:0] s,
                                                 input logic [31:0] d);
      if (l) return d << s;
      if (r) return d >> s;
      if (m) return 32'($signed(d) >>> s);
      return 32'hDEAD_BEEF;
   endfunction

   assign bus.sh_result  = shifter_model(bus.sh_left, bus.sh_right, bus.sh_math, bus.sh_src, bus.sh_dst);
   assign bus.sh_cf      = cf_drive;
   assign fbus.sh_result = shifter_model(fbus.sh_left, fbus.sh_right, fbus.sh_math, fbus.sh_src, fbus.sh_dst);
   assign fbus.sh_cf     = cf_drive;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present a request on bus, wait (bounded) for req_ready, complete the handshake.
   task automatic issue(input int unsigned port, input logic [1:0] op,
                        input logic [31:0] src, input logic [31:0] dst);
      int unsigned waited;
      waited = 0;
      if (port == 0) begin
         bus.req_valid0 = 1'b1; bus.req_op0 = op; bus.req_src0 = src; bus.req_dst0 = dst;
      end else begin
         bus.req_valid1 = 1'b1; bus.req_op1 = op; bus.req_src1 = src; bus.req_dst1 = dst;
      end
      #1;
      while (!(port == 0 ? bus.req_ready0 : bus.req_ready1) && waited < 20) begin
         tick;
         waited++;
      end
      if (waited >= 20) check("accept_timeout", 32'd0, 32'd1);
      tick;
      if (port == 0) bus.req_valid0 = 1'b0;
      else           bus.req_valid1 = 1'b0;
   endtask

   task automatic finish_rsp(input int unsigned port);
      if (port == 0) bus.rsp_ready0 = 1'b1;
      else           bus.rsp_ready1 = 1'b1;
      tick;
      bus.rsp_ready0 = 1'b0;
      bus.rsp_ready1 = 1'b0;
      check("rsp_drop", port == 0 ? bus.rsp_valid0 : bus.rsp_valid1, 32'd0);
      check("idle_busy", bus.busy, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst = 1'b1;
      cf_drive = 1'b0;
      bus.req_valid0 = 0; bus.req_valid1 = 0; bus.req_op0 = '0; bus.req_op1 = '0;
      bus.req_src0 = '0; bus.req_src1 = '0; bus.req_dst0 = '0; bus.req_dst1 = '0;
      bus.rsp_ready0 = 0; bus.rsp_ready1 = 0;
      fbus.req_valid0 = 0; fbus.req_valid1 = 0; fbus.req_op0 = '0; fbus.req_op1 = '0;
      fbus.req_src0 = '0; fbus.req_src1 = '0; fbus.req_dst0 = '0; fbus.req_dst1 = '0;
      fbus.rsp_ready0 = 0; fbus.rsp_ready1 = 0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      check("rst_busy", bus.busy, 32'd0);
      check("rst_ready", {bus.req_ready0, bus.req_ready1}, 32'd0);
      check("rst_rsp_valid", {bus.rsp_valid0, bus.rsp_valid1}, 32'd0);
      check("rst_sh_src", bus.sh_src, 32'd0);
      check("rst_sh_ctrl", {bus.sh_left, bus.sh_right, bus.sh_math}, 32'd0);
      rst = 1'b0;
      tick;

      // Port 0 logical left: 0xF1 << 4
      cf_drive = 1'b1;
      issue(0, 2'b00, 32'd4, 32'h0000_00F1);
      check("l_exec_busy", bus.busy, 32'd1);
      check("l_exec_ctrl", {bus.sh_left, bus.sh_right, bus.sh_math}, 32'b100);
      check("l_exec_src", bus.sh_src, 32'd4);
      check("l_exec_dst", bus.sh_dst, 32'h0000_00F1);
      check("l_exec_valid", bus.rsp_valid0, 32'd0);
      tick;
      check("l_rsp_valid0", bus.rsp_valid0, 32'd1);
      check("l_rsp_valid1", bus.rsp_valid1, 32'd0);
      check("l_result", bus.rsp_result0, 32'h0000_0F10);
      check("l_cf", bus.rsp_cf0, 32'd1);
      check("l_ctrl_off", {bus.sh_left, bus.sh_right, bus.sh_math}, 32'd0);
      finish_rsp(0);

      // Port 1 arithmetic right, then logical right
      cf_drive = 1'b0;
      issue(1, 2'b10, 32'd4, 32'h8000_0000);
      check("a_exec_ctrl", {bus.sh_left, bus.sh_right, bus.sh_math}, 32'b001);
      tick;
      check("a_rsp_valid1", bus.rsp_valid1, 32'd1);
      check("a_rsp_valid0", bus.rsp_valid0, 32'd0);
      check("a_result", bus.rsp_result1, 32'hF800_0000);
      finish_rsp(1);
      issue(1, 2'b01, 32'd4, 32'h8000_0000);
      check("r_exec_ctrl", {bus.sh_left, bus.sh_right, bus.sh_math}, 32'b010);
      tick;
      check("r_result", bus.rsp_result1, 32'h0800_0000);
      finish_rsp(1);

      // Round-robin after reset: both ports request continuously
      rst = 1'b1;
      #1;
      rst = 1'b0;
      tick;
      bus.req_valid0 = 1; bus.req_op0 = 2'b00; bus.req_src0 = 32'd8; bus.req_dst0 = 32'h0000_00AB;
      bus.req_valid1 = 1; bus.req_op1 = 2'b01; bus.req_src1 = 32'd8; bus.req_dst1 = 32'hAB00_0000;
      bus.rsp_ready0 = 1; bus.rsp_ready1 = 1;
      #1;
      for (int k = 0; k < 4; k++) begin
         int unsigned w;
         w = 0;
         while (!(bus.req_ready0 || bus.req_ready1) && w < 20) begin
            tick;
            w++;
         end
         if (w >= 20) check("rr_timeout", 32'd0, 32'd1);
         check($sformatf("rr_ready0_%0d", k), bus.req_ready0, 32'((k % 2) == 0));
         check($sformatf("rr_ready1_%0d", k), bus.req_ready1, 32'((k % 2) == 1));
         tick;
         tick;
         if ((k % 2) == 0) begin
            check($sformatf("rr_valid_%0d", k), {bus.rsp_valid0, bus.rsp_valid1}, 32'b10);
            check($sformatf("rr_res_%0d", k), bus.rsp_result0, 32'h0000_AB00);
         end else begin
            check($sformatf("rr_valid_%0d", k), {bus.rsp_valid0, bus.rsp_valid1}, 32'b01);
            check($sformatf("rr_res_%0d", k), bus.rsp_result1, 32'h00AB_0000);
         end
         tick;
      end
      bus.req_valid0 = 0; bus.req_valid1 = 0;
      bus.rsp_ready0 = 0; bus.rsp_ready1 = 0;

      // Fixed priority: port 0 wins every time
      fbus.req_valid0 = 1; fbus.req_op0 = 2'b00; fbus.req_src0 = 32'd1; fbus.req_dst0 = 32'h0000_0003;
      fbus.req_valid1 = 1; fbus.req_op1 = 2'b11; fbus.req_src1 = 32'd0; fbus.req_dst1 = 32'h5555_5555;
      fbus.rsp_ready0 = 1; fbus.rsp_ready1 = 1;
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("fp_ready_%0d", k), {fbus.req_ready0, fbus.req_ready1}, 32'b10);
         tick;
         tick;
         check($sformatf("fp_valid_%0d", k), {fbus.rsp_valid0, fbus.rsp_valid1}, 32'b10);
         check($sformatf("fp_res_%0d", k), fbus.rsp_result0, 32'h0000_0006);
         tick;
      end
      fbus.req_valid0 = 0; fbus.req_valid1 = 0;
      fbus.rsp_ready0 = 0; fbus.rsp_ready1 = 0;
      tick;

      // Backpressure on port 0 with port 1 (pass-through) waiting
      issue(0, 2'b00, 32'd1, 32'd1);
      cf_drive = 1'b1;
      bus.req_valid1 = 1; bus.req_op1 = 2'b11; bus.req_src1 = 32'd0; bus.req_dst1 = 32'h1234_5678;
      #1;
      check("bp_exec_ready1", bus.req_ready1, 32'd0);
      tick;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_valid0_%0d", i), bus.rsp_valid0, 32'd1);
         check($sformatf("bp_res0_%0d", i), bus.rsp_result0, 32'd2);
         check($sformatf("bp_ready1_%0d", i), bus.req_ready1, 32'd0);
         tick;
      end
      bus.rsp_ready0 = 1'b1;
      tick;
      bus.rsp_ready0 = 1'b0;
      check("bp_release_valid0", bus.rsp_valid0, 32'd0);
      check("bp_grant1", bus.req_ready1, 32'd1);
      tick;
      bus.req_valid1 = 1'b0;
      check("pt_exec_busy", bus.busy, 32'd1);
      check("pt_exec_ctrl", {bus.sh_left, bus.sh_right, bus.sh_math}, 32'd0);
      tick;
      check("pt_valid1", bus.rsp_valid1, 32'd1);
      check("pt_result", bus.rsp_result1, 32'h1234_5678);
      check("pt_cf", bus.rsp_cf1, 32'd0);
      check("pt_rsp_ctrl", {bus.sh_left, bus.sh_right, bus.sh_math}, 32'd0);
      finish_rsp(1);

      // Reset in the middle of EXEC
      issue(0, 2'b00, 32'd2, 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("mr_busy", bus.busy, 32'd0);
      check("mr_ctrl", {bus.sh_left, bus.sh_right, bus.sh_math}, 32'd0);
      check("mr_sh_src", bus.sh_src, 32'd0);
      check("mr_sh_dst", bus.sh_dst, 32'd0);
      check("mr_rsp_valid", {bus.rsp_valid0, bus.rsp_valid1}, 32'd0);
      check("mr_res0", bus.rsp_result0, 32'd0);
      check("mr_res1", bus.rsp_result1, 32'd0);
      check("mr_cf", {bus.rsp_cf0, bus.rsp_cf1}, 32'd0);
      check("mr_ready", {bus.req_ready0, bus.req_ready1}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         check($sformatf("mr_no_rsp_%0d", i), {bus.rsp_valid0, bus.busy}, 32'd0);
      end
      cf_drive = 1'b0;
      issue(0, 2'b00, 32'd2, 32'd3);
      tick;
      check("mr_next_valid", bus.rsp_valid0, 32'd1);
      check("mr_next_res", bus.rsp_result0, 32'h0000_000C);
      check("mr_next_cf", bus.rsp_cf0, 32'd0);
      finish_rsp(0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Sequencing and arbitration front end for the EX-stage 32-bit barrel shifter. Two requesters share one shifter: the integer ALU path on port 0 and the multi-word/rotate helper on port 1. The block accepts one request at a time over a valid/ready handshake and drives the shifter's control and operand inputs. It registers the shifter's result and carry flag and returns them to the winning requester over a held response handshake. The shifter is instantiated outside this block and wired to the `sh_*` ports.

## Interface
- `FIXED_PRIO`, default 0: 0 selects round-robin arbitration; 1 makes port 0 always win a simultaneous request.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `req_valid0` / `req_valid1`  input  1  request present on port 0 / port 1.
- `req_ready0` / `req_ready1`  output  1  request accepted this cycle on port 0 / port 1.
- `req_src0` / `req_src1`  input  32  shift amount operand, passed to the shifter unmodified.
- `req_dst0` / `req_dst1`  input  32  value to be shifted.
- `req_op0` / `req_op1`  input  2  operation: 00 logical left, 01 logical right, 10 arithmetic right, 11 pass-through.
- `rsp_valid0` / `rsp_valid1`  output  1  response available on port 0 / port 1.
- `rsp_ready0` / `rsp_ready1`  input  1  requester takes the response.
- `rsp_result0` / `rsp_result1`  output  32  registered shift result.
- `rsp_cf0` / `rsp_cf1`  output  1  registered carry flag.
- `sh_src`, `sh_dst`  output  32  shifter operands.
- `sh_left`, `sh_right`, `sh_math`  output  1  one-hot shifter controls.
- `sh_result`  input  32  shifter result.
- `sh_cf`  input  1  shifter carry flag.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - `req_ready` is asserted combinationally to exactly one port that has `req_valid` high; it is never asserted to a port without a request.
  - On handshake, latch src, dst, op and the owner id, then go to EXEC.
- **Arbitration:**
  - A request only on one port wins.
  - When both ports request with `FIXED_PRIO`=0, the port selected by the round-robin pointer wins. After each grant the pointer moves to the other port. Reset value of the pointer: port 0.
  - With `FIXED_PRIO`=1, port 0 wins.
- **EXEC:**
  - Drive `sh_src`/`sh_dst` from the latched operands.
  - Decode op: 00 drives `sh_left`, 01 drives `sh_right`, 10 drives `sh_math`, 11 drives none of them.
  - Capture `sh_result` and `sh_cf` into the response registers. For op 11, capture result = latched dst and cf = 0.
  - Go to RESP.
- **RESP:**
  - The owner's `rsp_valid` is high; the other port's `rsp_valid` is low.
  - Result and cf are held stable until the owner's `rsp_ready` is high. On that edge, go to IDLE.
  - The `rsp_ready` of the non-owner port is ignored.
- Outside EXEC: `sh_left`, `sh_right` and `sh_math` are 0. `sh_src` and `sh_dst` hold their last values, and are 0 after reset.
- Width rule: there is no masking of `req_src`. Amounts of 32 or more take whatever semantics the shifter defines.
- **Reset (any state, including mid-EXEC or RESP):**
  - Immediately: state goes to IDLE, `rsp_valid*` to 0, `busy` to 0, `sh_*` controls to 0, and result/cf registers, operand registers and the pointer to 0.
  - The in-flight transaction is discarded with no response.

## Timing
- The request handshake completes at edge N (rising edge with `req_valid`&`req_ready` high).
- EXEC occupies the cycle after edge N.
- `rsp_valid` rises after edge N+1. Minimum latency is 2 cycles from accept to response.
- `req_ready0` and `req_ready1` are 0 throughout EXEC and RESP.
- Response accepted at edge M: `req_ready` may assert again in the cycle after M.
- Peak throughput: one operation per 3 cycles.
- `req_ready` depends combinationally only on `req_valid*`, the state and the pointer. It never depends on `rsp_ready`.
- Values after reset: `req_ready*` are 0 unless a `req_valid` is high; all other outputs are 0.

## Test plan
- **Port 0 left shift:** op=00, src=4, dst=0x0000_00F1.
  - `rsp_valid0` is high 2 cycles after accept.
  - `rsp_result0`=0x0000_0F10 and `rsp_cf0` equals `sh_cf` sampled in EXEC.
- **Port 1 arithmetic right:** op=10, src=4, dst=0x8000_0000 gives `rsp_result1`=0xF800_0000. Logical right (op=01) with the same operands gives 0x0800_0000.
- **Simultaneous requests after reset (`FIXED_PRIO`=0):**
  - Both ports request continuously with different operands.
  - Grants alternate 0,1,0,1 across four operations, and each result appears only on its owner port.
  - With `FIXED_PRIO`=1, port 0 is granted every time.
- **Backpressure:**
  - Hold `rsp_ready0`=0 for 5 cycles in RESP. `rsp_valid0` and `rsp_result0` stay stable, and `req_ready1` stays 0 despite `req_valid1`=1.
  - Release `rsp_ready0` and port 1 is granted the next cycle.
- **Pass-through:** op=11, dst=0x1234_5678 gives result 0x1234_5678 and cf=0; `sh_left`, `sh_right` and `sh_math` stay 0 throughout.
- **Reset mid-operation:**
  - Assert `rst` asynchronously during EXEC. All outputs are 0 before the next clock edge.
  - After release no response appears, and the next request completes normally.
